dffram_march_bist: RTL and testbench

- Built-in self-test initiator for the single-port DFFRAM macro family (CLK, WE0, EN0, A0, Di0, Do0).
- Drives the RAM port as the requesting side and runs a March C- sequence over every word, comparing returned Do0 against expected data.
- Reports pass/fail, the first failing address, element and syndrome, and a saturating error count.
- Sits beside the RAM; a system-level mux (outside this block) grants it the port while busy=1.

---
 rtl/dffram_march_bist.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_dffram_march_bist.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dffram_march_bist.sv
// March C- built-in self-test initiator for a single-port DFFRAM macro.
// Drives the RAM port, checks every read against the expected background,
// and reports pass/fail, first failing address/element/syndrome and an error count.
module dffram_march_bist #(
    parameter int unsigned   AW           = 8,
    parameter int unsigned   DW           = 32,
    parameter int unsigned   WSIZE        = 4,
    parameter logic [DW-1:0] PATTERN      = 32'h0000_0000,
    parameter bit            STOP_ON_FAIL = 1'b1
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [AW-1:0]    fail_addr,
    output logic [2:0]       fail_elem,
    output logic [DW-1:0]    fail_data,
    output logic [7:0]       err_count,
    output logic [WSIZE-1:0] WE0,
    output logic             EN0,
    output logic [AW-1:0]    A0,
    output logic [DW-1:0]    Di0,
    input  logic [DW-1:0]    Do0
);

    localparam logic [AW-1:0] AddrLast = {AW{1'b1}};
    localparam logic [AW-1:0] AddrOne  = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        StIdle,
        StM0,
        StM1,
        StM2,
        StM3,
        StM4,
        StM5,
        StCheck,
        StDone
    } state_e;

    // Sequencer state: element, address within element, read/write phase of a pair
    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          phase_q, phase_d;

    // Registered RAM port: always describes the operation of the current cycle
    logic          en_q, en_d;
    logic          we_q, we_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] di_q, di_d;

    // Pending compare: the read issued last cycle, checked against Do0 this cycle
    logic          chk_vld_q, chk_vld_d;
    logic [DW-1:0] chk_exp_q, chk_exp_d;
    logic [AW-1:0] chk_addr_q, chk_addr_d;
    logic [2:0]    chk_elem_q, chk_elem_d;

    // Result registers
    logic [7:0]    err_q, err_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]    fail_elem_q, fail_elem_d;
    logic [DW-1:0] fail_data_q, fail_data_d;
    logic          pass_q, pass_d;

    logic          active;
    logic          mismatch;
    logic          stop_kill;

    function automatic logic [2:0] elem_of(input state_e s);
        case (s)
            StM1:    elem_of = 3'd1;
            StM2:    elem_of = 3'd2;
            StM3:    elem_of = 3'd3;
            StM4:    elem_of = 3'd4;
            StM5:    elem_of = 3'd5;
            default: elem_of = 3'd0;
        endcase
    endfunction

    // Background value: 0 -> PATTERN, 1 -> ~PATTERN
    function automatic logic [DW-1:0] bg(input logic one);
        bg = one ? ~PATTERN : PATTERN;
    endfunction

    // Value an element expects to read back (r1 in M2/M4, r0 elsewhere)
    function automatic logic rd_one(input state_e s);
        rd_one = (s == StM2) || (s == StM4);
    endfunction

    // Value an element writes (w1 in M1/M3, w0 elsewhere)
    function automatic logic wr_one(input state_e s);
        wr_one = (s == StM1) || (s == StM3);
    endfunction

    // Compare the returned word and decide whether the run must stop now
    always_comb begin
        active    = state_q inside {StM0, StM1, StM2, StM3, StM4, StM5, StCheck};
        mismatch  = active && chk_vld_q && (Do0 != chk_exp_q);
        stop_kill = STOP_ON_FAIL && mismatch;
    end

    // Next sequencer position
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StM0;
                    addr_d  = '0;
                    phase_d = 1'b0;
                end
            end
            StM0: begin
                if (addr_q == AddrLast) begin
                    state_d = StM1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + AddrOne;
                end
            end
            StM1, StM2: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (addr_q == AddrLast) begin
                        state_d = (state_q == StM1) ? StM2 : StM3;
                        addr_d  = (state_q == StM1) ? '0 : AddrLast;
                    end else begin
                        addr_d = addr_q + AddrOne;
                    end
                end
            end
            StM3, StM4: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (addr_q == '0) begin
                        state_d = (state_q == StM3) ? StM4 : StM5;
                        addr_d  = (state_q == StM3) ? AddrLast : '0;
                    end else begin
                        addr_d = addr_q - AddrOne;
                    end
                end
            end
            StM5: begin
                if (addr_q == AddrLast) begin
                    state_d = StCheck;
                end else begin
                    addr_d = addr_q + AddrOne;
                end
            end
            StCheck: state_d = StDone;
            default: state_d = StIdle;
        endcase
        if (stop_kill) begin
            state_d = StDone;
        end
    end

    // RAM port values for the next cycle, derived from the next sequencer position
    always_comb begin
        en_d = 1'b0;
        we_d = 1'b0;
        a_d  = '0;
        di_d = '0;
        case (state_d)
            StM0: begin
                en_d = 1'b1;
                we_d = 1'b1;
                a_d  = addr_d;
                di_d = bg(1'b0);
            end
            StM1, StM2, StM3, StM4: begin
                en_d = 1'b1;
                a_d  = addr_d;
                if (phase_d) begin
                    we_d = 1'b1;
                    di_d = bg(wr_one(state_d));
                end
            end
            StM5: begin
                en_d = 1'b1;
                a_d  = addr_d;
            end
            default: ;
        endcase
    end

    // Capture the read issued this cycle so its data can be checked next cycle
    always_comb begin
        chk_vld_d  = en_q && !we_q && !stop_kill;
        chk_exp_d  = bg(rd_one(state_q));
        chk_addr_d = a_q;
        chk_elem_d = elem_of(state_q);
    end

    // Result bookkeeping: clear on accepted start, count and latch first mismatch
    always_comb begin
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_data_d = fail_data_q;
        pass_d      = pass_q;
        if ((state_q == StIdle || state_q == StDone) && start) begin
            err_d       = '0;
            fail_addr_d = '0;
            fail_elem_d = '0;
            fail_data_d = '0;
            pass_d      = 1'b0;
        end else if (mismatch) begin
            if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
            // err_q saturates rather than wraps, so zero means no earlier mismatch
            if (err_q == 8'd0) begin
                fail_addr_d = chk_addr_q;
                fail_elem_d = chk_elem_q;
                fail_data_d = Do0 ^ chk_exp_q;
            end
        end
        if (state_d == StDone && state_q != StDone) begin
            pass_d = (err_d == 8'd0);
        end
    end

    // State and port registers
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            a_q         <= '0;
            di_q        <= '0;
            chk_vld_q   <= 1'b0;
            chk_exp_q   <= '0;
            chk_addr_q  <= '0;
            chk_elem_q  <= '0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_data_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            en_q        <= en_d;
            we_q        <= we_d;
            a_q         <= a_d;
            di_q        <= di_d;
            chk_vld_q   <= chk_vld_d;
            chk_exp_q   <= chk_exp_d;
            chk_addr_q  <= chk_addr_d;
            chk_elem_q  <= chk_elem_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_data_q <= fail_data_d;
            pass_q      <= pass_d;
        end
    end

    // Outputs; a stopping mismatch squashes the write already on the port this cycle
    always_comb begin
        busy      = active;
        done      = (state_q == StDone);
        pass      = pass_q;
        fail_addr = fail_addr_q;
        fail_elem = fail_elem_q;
        fail_data = fail_data_q;
        err_count = err_q;
        EN0       = en_q && !stop_kill;
        WE0       = (we_q && !stop_kill) ? {WSIZE{1'b1}} : {WSIZE{1'b0}};
        A0        = a_q;
        Di0       = di_q;
    end

endmodule

// File: tb/tb_dffram_march_bist.sv
// Directed bench for dffram_march_bist: three BIST instances, each beside its own
// 256x32 RAM model (0: STOP_ON_FAIL=1 with optional stuck-at, 1: STOP_ON_FAIL=0 with
// stuck-at, 2: PATTERN=A5A5A5A5 with a 0x10->0x11 coupling fault).
module tb_dffram_march_bist;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic [2:0]  start;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  pass;
    logic [2:0]  en0;
    logic [2:0]  stuck_en;
    logic [7:0]  fail_addr [3];
    logic [2:0]  fail_elem [3];
    logic [31:0] fail_data [3];
    logic [7:0]  err_count [3];
    logic [3:0]  we0 [3];
    logic [7:0]  a0 [3];
    logic [31:0] di0 [3];

    int n_run  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] mem [256];
        logic [31:0] rdata;

        dffram_march_bist #(
            .AW          (8),
            .DW          (32),
            .WSIZE       (4),
            .PATTERN     ((g == 2) ? 32'hA5A5_A5A5 : 32'h0000_0000),
            .STOP_ON_FAIL((g == 1) ? 1'b0 : 1'b1)
        ) u_dut (
            .CLK      (CLK),
            .RESETn   (RESETn),
            .start    (start[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .pass     (pass[g]),
            .fail_addr(fail_addr[g]),
            .fail_elem(fail_elem[g]),
            .fail_data(fail_data[g]),
            .err_count(err_count[g]),
            .WE0      (we0[g]),
            .EN0      (en0[g]),
            .A0       (a0[g]),
            .Di0      (di0[g]),
            .Do0      (rdata)
        );

        // RAM model: byte-lane writes, registered read, optional faults
        always @(posedge CLK) begin
            if (en0[g]) begin
                if (we0[g] != 4'b0) begin
                    for (int b = 0; b < 4; b++) begin
                        if (we0[g][b]) begin
                            mem[a0[g]][8*b +: 8] <= di0[g][8*b +: 8];
                            if (g == 2 && a0[g] == 8'h10) begin
                                mem[8'h11][8*b +: 8] <= di0[g][8*b +: 8];
                            end
                        end
                    end
                end else begin
                    rdata <= mem[a0[g]] |
                             ((stuck_en[g] && a0[g] == 8'h2A) ? 32'h0000_0008 : 32'h0);
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start so it is sampled at one rising edge; returns #1 after that edge
    task automatic start_run(input int idx);
        @(negedge CLK);
        start[idx] = 1'b1;
        @(posedge CLK);
        #1;
        start[idx] = 1'b0;
    endtask

    // Count edges after the start edge until done; optionally re-pulse start at edge 500
    task automatic wait_done(input int idx, input bit restart, output int n);
        n = 0;
        while (!done[idx] && n < 3000) begin
            @(posedge CLK);
            #1;
            n++;
            if (restart && n == 500) start[idx] = 1'b1;
            if (restart && n == 501) start[idx] = 1'b0;
        end
    endtask

    int ncyc;
    int nz;

    initial begin
        RESETn   = 1'b0;
        start    = 3'b000;
        stuck_en = 3'b010;
        #23;
        // Async reset state
        check_eq("rst_busy", busy, 3'b000);
        check_eq("rst_done", done, 3'b000);
        check_eq("rst_pass", pass, 3'b000);
        check_eq("rst_en0", en0, 3'b000);
        check_eq("rst_we0", we0[0], 4'h0);
        check_eq("rst_a0", a0[0], 8'h00);
        check_eq("rst_di0", di0[0], 32'h0);
        check_eq("rst_err", err_count[0], 8'h00);
        check_eq("rst_faddr", fail_addr[0], 8'h00);
        check_eq("rst_felem", fail_elem[0], 3'd0);
        check_eq("rst_fdata", fail_data[0], 32'h0);
        @(negedge CLK);
        RESETn = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_eq("idle_en0", en0[0], 1'b0);

        // Run A: fault-free, with a start re-pulse while busy (must be ignored)
        start_run(0);
        check_eq("A_busy", busy[0], 1'b1);
        check_eq("A_en0", en0[0], 1'b1);
        check_eq("A_we0", we0[0], 4'hF);
        wait_done(0, 1'b1, ncyc);
        check_eq("A_cycles", ncyc, 2561);
        check_eq("A_done", done[0], 1'b1);
        check_eq("A_busy_end", busy[0], 1'b0);
        check_eq("A_pass", pass[0], 1'b1);
        check_eq("A_err", err_count[0], 8'd0);
        @(posedge CLK);
        #1;
        check_eq("A_en0_after", en0[0], 1'b0);
        check_eq("A_we0_after", we0[0], 4'h0);
        nz = 0;
        for (int i = 0; i < 256; i++) begin
            if (g_dut[0].mem[i] != 32'h0) nz++;
        end
        check_eq("A_mem_zero", nz, 0);

        // Run B: stuck-at-1 bit 3 of 0x2A, stop at first fail in M1
        stuck_en[0] = 1'b1;
        start_run(0);
        check_eq("B_done_clr", done[0], 1'b0);
        check_eq("B_pass_clr", pass[0], 1'b0);
        check_eq("B_busy", busy[0], 1'b1);
        wait_done(0, 1'b0, ncyc);
        check_eq("B_cycles", ncyc, 342);
        check_eq("B_faddr", fail_addr[0], 8'h2A);
        check_eq("B_felem", fail_elem[0], 3'd1);
        check_eq("B_fdata", fail_data[0], 32'h0000_0008);
        check_eq("B_err", err_count[0], 8'd1);
        check_eq("B_pass", pass[0], 1'b0);
        check_eq("B_en0", en0[0], 1'b0);
        check_eq("B_w1_suppressed", g_dut[0].mem[8'h2A], 32'h0);
        check_eq("B_w1_prev", g_dut[0].mem[8'h29], 32'hFFFF_FFFF);

        // Run C: same fault, run to completion and count
        start_run(1);
        wait_done(1, 1'b0, ncyc);
        check_eq("C_cycles", ncyc, 2561);
        check_eq("C_err", err_count[1], 8'd3);
        check_eq("C_faddr", fail_addr[1], 8'h2A);
        check_eq("C_felem", fail_elem[1], 3'd1);
        check_eq("C_fdata", fail_data[1], 32'h0000_0008);
        check_eq("C_pass", pass[1], 1'b0);

        // Run D: coupling fault under the A5A5 background
        start_run(2);
        wait_done(2, 1'b0, ncyc);
        check_eq("D_done", done[2], 1'b1);
        check_eq("D_faddr", fail_addr[2], 8'h11);
        check_eq("D_felem", fail_elem[2], 3'd1);
        check_eq("D_fdata", fail_data[2], 32'hFFFF_FFFF);
        check_eq("D_pass", pass[2], 1'b0);

        // Run E: restart from DONE clears results; reset mid-run is immediate
        stuck_en[0] = 1'b0;
        start_run(0);
        check_eq("E_err_clr", err_count[0], 8'd0);
        check_eq("E_faddr_clr", fail_addr[0], 8'h00);
        check_eq("E_felem_clr", fail_elem[0], 3'd0);
        check_eq("E_fdata_clr", fail_data[0], 32'h0);
        repeat (700) @(posedge CLK);
        #1;
        check_eq("E_pre_busy", busy[0], 1'b1);
        check_eq("E_pre_en0", en0[0], 1'b1);
        #2;
        RESETn = 1'b0;
        #1;
        check_eq("E_rst_en0", en0[0], 1'b0);
        check_eq("E_rst_we0", we0[0], 4'h0);
        check_eq("E_rst_busy", busy[0], 1'b0);
        check_eq("E_rst_done", done[0], 1'b0);
        @(negedge CLK);
        RESETn = 1'b1;
        start_run(0);
        wait_done(0, 1'b0, ncyc);
        check_eq("E_cycles", ncyc, 2561);
        check_eq("E_pass", pass[0], 1'b1);
        check_eq("E_err", err_count[0], 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
